// File: rtl/forward_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard: operand-mux select codes,
// the scoreboard entry layout and the per-cycle entry aging rule.
package forward_scoreboard_pkg;

  localparam logic [1:0] FWD_SEL_REGFILE = 2'd0;
  localparam logic [1:0] FWD_SEL_MEM_WB  = 2'd1;
  localparam logic [1:0] FWD_SEL_EX_MEM  = 2'd2;

  // Entry fields are sized for the widest supported configuration; narrower
  // register indices are zero-extended into rd.
  localparam int unsigned SB_RD_W  = 8;
  localparam int unsigned SB_CNT_W = 4;

  typedef struct packed {
    logic                valid;
    logic [SB_RD_W-1:0]  rd;
    logic [SB_CNT_W-1:0] cnt;
    logic                wb;
  } sb_entry_t;

  // One cycle of progress: count down to EX_MEM, then one cycle in MEM_WB, then free.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (e.valid) begin
      if (e.wb) begin
        r = '0;
      end else if (e.cnt == '0) begin
        r.wb = 1'b1;
      end else begin
        r.cnt = e.cnt - SB_CNT_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/forward_scoreboard_fwd_match.sv
// Youngest-match lookup of one source register against the scoreboard, producing the
// dependency stall and the operand-mux select for the next cycle.
module forward_scoreboard_fwd_match
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 5
) (
  input  logic [REG_ADDR_W-1:0]  rs,
  input  sb_entry_t [DEPTH-1:0]  entries,
  output logic                   dep_stall,
  output logic [1:0]             sel
);

  logic                hit;
  logic [SB_CNT_W-1:0] hit_cnt;
  logic                hit_wb;

  // Scan oldest to youngest so the youngest match (index 0 side) wins.
  always_comb begin
    hit     = 1'b0;
    hit_cnt = '0;
    hit_wb  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && (rs != '0) && (entries[i].rd == SB_RD_W'(rs))) begin
        hit     = 1'b1;
        hit_cnt = entries[i].cnt;
        hit_wb  = entries[i].wb;
      end
    end
  end

  always_comb begin
    dep_stall = hit && (hit_cnt > SB_CNT_W'(1));
    sel       = FWD_SEL_REGFILE;
    if (hit && !hit_wb) begin
      if (hit_cnt == SB_CNT_W'(1)) begin
        sel = FWD_SEL_EX_MEM;
      end else if (hit_cnt == '0) begin
        sel = FWD_SEL_MEM_WB;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Issue-stage scoreboard: tracks in-flight register writers with mixed ALU/multiplier
// latency, stalls on unready operands or write-port conflicts, and registers forward selects.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned MULT_LAT   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic                          id_reg_write,
  input  logic                          id_is_mult,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  output logic                          stall,
  output logic                          ex_valid,
  output logic [NUM_SRC*2-1:0]          ex_fwd_sel
);

  localparam int unsigned DEPTH = MULT_LAT + 2;

  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t [DEPTH-1:0] sb_d;
  sb_entry_t [DEPTH-1:0] sb_aged;
  sb_entry_t             new_entry;

  logic [NUM_SRC-1:0]    src_stall;
  logic [NUM_SRC*2-1:0]  next_sel;
  logic [SB_CNT_W-1:0]   wr_lat;
  logic                  port_conflict;
  logic                  issue;
  logic                  alloc;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    forward_scoreboard_fwd_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (DEPTH)
    ) u_fwd_match (
      .rs        (id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .entries   (sb_q),
      .dep_stall (src_stall[k]),
      .sel       (next_sel[2*k +: 2])
    );
  end

  assign wr_lat = id_is_mult ? SB_CNT_W'(MULT_LAT) : SB_CNT_W'(1);

  // A writer of latency L would reach EX_MEM together with any entry now at L+1.
  always_comb begin
    port_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_q[i].valid && (sb_q[i].cnt == wr_lat + SB_CNT_W'(1))) begin
        port_conflict = 1'b1;
      end
    end
  end

  assign stall = id_valid & ~rst & ((|src_stall) | (id_reg_write & port_conflict));
  assign issue = id_valid & ~rst & ~stall;
  assign alloc = issue & id_reg_write & (id_rd != '0);

  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.rd    = SB_RD_W'(id_rd);
    new_entry.cnt   = wr_lat;
    new_entry.wb    = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sb_aged[i] = sb_age(sb_q[i]);
    end
    sb_d = sb_aged;
    if (alloc) begin
      sb_d[0] = new_entry;
      for (int i = 1; i < DEPTH; i++) begin
        sb_d[i] = sb_aged[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q       <= '0;
      ex_valid   <= 1'b0;
      ex_fwd_sel <= '0;
    end else begin
      sb_q       <= sb_d;
      ex_valid   <= issue;
      ex_fwd_sel <= stall ? '0 : next_sel;
    end
  end

  // Single issue with bounded latency keeps the oldest slot free whenever we allocate.
  sb_overflow_a: assert property (@(posedge clk) disable iff (rst)
    alloc |-> !sb_aged[DEPTH-1].valid)
    else $error("forward_scoreboard: allocation with no free entry");

endmodule

// File: tb/tb_forward_scoreboard.sv
// Randomised and directed bench for forward_scoreboard against a timing-based reference model.
module tb_forward_scoreboard;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned ML = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               id_valid = 1'b0;
  logic               id_reg_write = 1'b0;
  logic               id_is_mult = 1'b0;
  logic [AW-1:0]      id_rd = '0;
  logic [NS*AW-1:0]   id_rs = '0;
  logic               stall;
  logic               ex_valid;
  logic [NS*2-1:0]    ex_fwd_sel;

  always #5 clk = ~clk;

  forward_scoreboard #(
    .REG_ADDR_W (AW),
    .NUM_SRC    (NS),
    .MULT_LAT   (ML)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_reg_write (id_reg_write),
    .id_is_mult   (id_is_mult),
    .id_rd        (id_rd),
    .id_rs        (id_rs),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_fwd_sel   (ex_fwd_sel)
  );

  // A pending write: destination, ID cycle it issued in, and its latency to EX_MEM.
  typedef struct {
    int rd;
    int t;
    int lat;
  } wr_t;

  wr_t          pend[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic         exp_ex_valid = 1'b0;
  logic [3:0]   exp_ex_sel = '0;
  logic         last_stall = 1'b0;
  logic         obs_ex_valid;
  logic [3:0]   obs_ex_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycles remaining until the write reaches EX_MEM, seen from ID at cycle c.
  // >1: not ready; 1: EX_MEM next; 0: MEM_WB next; -1: already in regfile path; < -1: gone.
  function automatic int remaining(input wr_t w, input int c);
    return w.t + w.lat + 1 - c;
  endfunction

  function automatic void model_src(input int rs, output logic dep, output logic [1:0] sel);
    int rem;
    dep = 1'b0;
    sel = 2'd0;
    if (rs == 0) return;
    for (int i = 0; i < pend.size(); i++) begin
      rem = remaining(pend[i], cyc);
      if (pend[i].rd == rs && rem >= -1) begin
        dep = (rem > 1);
        sel = (rem == 1) ? 2'd2 : (rem == 0) ? 2'd1 : 2'd0;
      end
    end
  endfunction

  task automatic step(input logic v, input logic rw, input logic m, input logic [AW-1:0] rd,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic r);
    logic       d0, d1, conflict, m_stall, m_issue;
    logic [1:0] s0, s1;
    int         lat;
    @(posedge clk);
    #1;
    obs_ex_valid = ex_valid;
    obs_ex_sel   = ex_fwd_sel;
    check("ex_valid", ex_valid, exp_ex_valid);
    check("ex_fwd_sel", ex_fwd_sel, exp_ex_sel);
    cyc++;
    rst          = r;
    id_valid     = v;
    id_reg_write = rw;
    id_is_mult   = m;
    id_rd        = rd;
    id_rs        = {r1, r0};
    #1;
    model_src(int'(r0), d0, s0);
    model_src(int'(r1), d1, s1);
    lat      = m ? ML : 1;
    conflict = 1'b0;
    foreach (pend[i]) if (remaining(pend[i], cyc) == lat + 1) conflict = 1'b1;
    m_stall = v && !r && (d0 || d1 || (rw && conflict));
    check("stall", stall, m_stall);
    last_stall = stall;
    m_issue = v && !r && !m_stall;
    if (r) begin
      pend.delete();
      exp_ex_valid = 1'b0;
      exp_ex_sel   = '0;
    end else begin
      exp_ex_valid = m_issue;
      exp_ex_sel   = m_stall ? 4'd0 : {s1, s0};
      if (m_issue && rw && rd != 0) pend.push_back('{int'(rd), cyc, lat});
    end
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (remaining(pend[i], cyc + 1) < -1) pend.delete(i);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  logic          rv, rrw, rm, rr;
  logic [AW-1:0] rrd, rr0, rr1;
  int            nst;

  initial begin
    // Reset with a valid consumer present: stall must stay low.
    step(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 5'd4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4, 1'b1);
    check("rst_stall", last_stall, 1'b0);
    idle(2);
    check("rst_ex_valid", obs_ex_valid, 1'b0);

    // ALU r5 then immediate consumer: EX_MEM forward.
    step(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    check("alu_b2b_stall", last_stall, 1'b0);
    idle(1);
    check("alu_b2b_sel", obs_ex_sel[1:0], 2'd2);
    idle(4);

    // ALU r5, unrelated, consumer (MEM_WB), then another consumer (regfile).
    step(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    check("alu_gap1_sel", obs_ex_sel[1:0], 2'd1);
    idle(1);
    check("alu_gap2_sel", obs_ex_sel[1:0], 2'd0);
    idle(4);

    // MULT r7 then immediate consumer: two stall cycles then EX_MEM.
    step(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
      if (!last_stall) break;
      nst++;
    end
    check("mult_stalls", nst, 2);
    idle(1);
    check("mult_sel", obs_ex_sel[1:0], 2'd2);
    idle(5);

    // MULT r7, ALU r7, consumer: youngest (ALU) wins, no stall.
    step(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    check("youngest_stall", last_stall, 1'b0);
    idle(1);
    check("youngest_sel", obs_ex_sel[3:2], 2'd2);
    idle(5);

    // MULT two cycles ahead of an ALU writer: one cycle of port-conflict stall.
    step(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd10, 5'd1, 5'd2, 1'b0);
      if (!last_stall) break;
      nst++;
    end
    check("port_stalls", nst, 1);
    idle(5);

    // Writer of r0 then consumer of r0 on both sources.
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("r0_stall", last_stall, 1'b0);
    idle(1);
    check("r0_sel", obs_ex_sel, 4'd0);
    idle(3);

    // Reset while a MULT is pending discards it.
    step(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    check("rst_mid_stall", last_stall, 1'b0);
    idle(1);
    check("rst_mid_ex_valid", obs_ex_valid, 1'b1);
    check("rst_mid_sel", obs_ex_sel, 4'd0);

    // Random traffic; a stalled instruction is held in ID.
    rv = 0; rrw = 0; rm = 0; rr = 0; rrd = '0; rr0 = '0; rr1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall || rr) begin
        rv  = ($urandom_range(0, 99) < 80);
        rrw = ($urandom_range(0, 99) < 70);
        rm  = ($urandom_range(0, 99) < 30);
        rrd = AW'($urandom_range(0, 7));
        rr0 = AW'($urandom_range(0, 7));
        rr1 = AW'($urandom_range(0, 7));
      end
      rr = ($urandom_range(0, 99) < 2);
      step(rv, rrw, rm, rrd, rr0, rr1, rr);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter REG_ADDR_W, default 5, sets the register-index width.
REQ-002 Parameter NUM_SRC, default 2, sets the number of source operands per instruction.
REQ-003 Parameter MULT_LAT, default 3, sets the multiplier latency in cycles until the result reaches EX_MEM; range 2..8.
REQ-004 Port clk, input, 1, is the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-006 Port id_valid, input, 1, flags a valid instruction in ID.
REQ-007 Port id_reg_write, input, 1, flags that the ID instruction writes id_rd.
REQ-008 Port id_is_mult, input, 1, selects multiplier latency (MULT_LAT) versus ALU latency (1).
REQ-009 Port id_rd, input, REG_ADDR_W, is the ID destination register.
REQ-010 Port id_rs, input, NUM_SRC*REG_ADDR_W, carries the packed ID source registers; source k is at slice k.
REQ-011 Port stall, output, 1, holds IF/ID and inserts a bubble when high (combinational).
REQ-012 Port ex_valid, output, 1, flags that the instruction now in EX was issued (registered).
REQ-013 Port ex_fwd_sel, output, NUM_SRC*2, carries the registered per-source 3-input operand-mux select: 2 = EX_MEM, 1 = MEM_WB, 0 = ID_EX/regfile value.

Function
REQ-014 The block shall hold a scoreboard of MULT_LAT+2 entries, each {valid, rd, cnt, wb}; cnt is the number of cycles until the result is in EX_MEM.
REQ-015 Issue shall be id_valid & ~stall; allocation shall occur only on issue with id_reg_write=1 and id_rd!=0, writing cnt = (id_is_mult ? MULT_LAT : 1), wb=0.
REQ-016 Every cycle, each valid entry shall update as follows: cnt>0 decrements; cnt==0 & wb==0 sets wb=1 (result now in MEM_WB); wb==1 frees the entry.
REQ-017 For each source k with rs!=0, the youngest valid entry whose rd matches shall determine the dependency; rs==0 never matches.
REQ-018 A matching entry with cnt>1 shall force stall=1.
REQ-019 The forwarding select shall be chosen from the match: cnt==1 gives next sel 2; cnt==0 & wb==0 gives next sel 1; wb==1 or no match gives next sel 0.
REQ-020 A write-port conflict shall force stall=1: an issuing writer with latency L stalls if any valid entry has cnt==L+1.
REQ-021 stall shall be 0 whenever id_valid=0.
REQ-022 On each clock, ex_valid shall load the issue condition and ex_fwd_sel shall load the next-sel values; on stall, ex_valid=0 and ex_fwd_sel=0.
REQ-023 Scoreboard overflow is impossible by construction (single issue, bounded latency); an assertion shall flag any allocation with no free entry.
REQ-024 Stall-to-output latency shall be 0 cycles; forward select latency shall be 1 cycle (ID to EX).

Reset
REQ-025 While rst=1, all entries shall be invalid, and ex_valid=0 and ex_fwd_sel=0 on the following edge.
REQ-026 Reset mid-operation shall discard all in-flight entries.
REQ-027 stall shall evaluate to 0 during reset because all entries are invalid.

Structure
REQ-028 The shared package shall hold the FWD_SEL_REGFILE=0, FWD_SEL_MEM_WB=1, FWD_SEL_EX_MEM=2 constants and the scoreboard-entry typedef.
REQ-029 A sub-module fwd_match (one source-versus-scoreboard youngest-match lookup) shall be instantiated NUM_SRC times.
REQ-030 Age ordering shall be kept by allocating into a shift-ordered array (index 0 = youngest).

Verification
REQ-031 ALU write r5, then next-cycle consumer rs0=r5 -> stall=0, following-cycle ex_fwd_sel[1:0]=2.
REQ-032 ALU write r5, one unrelated instruction, then consumer of r5 -> ex_fwd_sel=1; a third-cycle consumer -> sel=0.
REQ-033 MULT write r7 (MULT_LAT=3), then immediate consumer of r7 -> stall for 2 cycles, then issue with sel=2.
REQ-034 MULT to r7, then ALU to r7, then consumer of r7 -> youngest (ALU) match used; MULT issued two cycles before an ALU writer -> ALU stalls 1 cycle (port conflict).
REQ-035 Consumer with rs0=r0, rs1=r0 after a writer of r0 -> no stall, sel=0 on both sources.
REQ-036 rst=1 asserted while a MULT is pending -> next cycle the consumer of its rd issues with stall=0, sel=0, ex_valid reflecting the new issue.
